// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream in / register-write out bundle for spi_cmd_decoder.
// The decoder uses the slave modport; the upstream byte source and any write observer use master.
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 4
) ();
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output rx_byte, rx_valid,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_byte, rx_valid,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Frames SPI bytes (A5, ADDR, DATA[, CHK]) into control-register writes, with timeout and error counting.
// Optional trailing checksum byte enabled by defining SPI_CMD_CHECKSUM_EN.
module spi_cmd_decoder #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int ADDR_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_cmd_decoder_if.slave      bus,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  frame_err,
  output logic [7:0]            err_count,
  output logic                  busy
);

  localparam int               CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       NUM_REGS_EXT = 9'(NUM_REGS);
  localparam logic [7:0]       SYNC_BYTE    = 8'hA5;

  typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic              wrEn_q, frameErr_q, busy_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [7:0]        wrData_q, errCount_q;
  logic [7:0]        regs_q [NUM_REGS];
  logic              commit, error;
  logic [7:0]        commitData;
  logic              rxOor;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]        data_q, data_d;
  logic [7:0]        chk_q, chk_d;
`endif

  assign rxOor = {1'b0, bus.rx_byte} >= NUM_REGS_EXT;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    commit     = 1'b0;
    error      = 1'b0;
    commitData = bus.rx_byte;
`ifdef SPI_CMD_CHECKSUM_EN
    data_d     = data_q;
    chk_d      = chk_q;
    commitData = data_q;
`endif

    // A byte arriving on the terminal-count cycle takes priority over the timeout.
    if (state_q == IDLE || bus.rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TERM) begin
      cnt_d   = '0;
      error   = 1'b1;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_byte == SYNC_BYTE) state_d = GET_ADDR;
        end
        GET_ADDR: begin
          addr_d  = bus.rx_byte[ADDR_W-1:0];
          oor_d   = rxOor;
          state_d = GET_DATA;
`ifdef SPI_CMD_CHECKSUM_EN
          chk_d   = SYNC_BYTE ^ bus.rx_byte;
`endif
        end
        GET_DATA: begin
`ifdef SPI_CMD_CHECKSUM_EN
          data_d  = bus.rx_byte;
          chk_d   = chk_q ^ bus.rx_byte;
          state_d = GET_CHK;
`else
          state_d = IDLE;
          error   = oor_q;
          commit  = !oor_q;
`endif
        end
`ifdef SPI_CMD_CHECKSUM_EN
        GET_CHK: begin
          state_d = IDLE;
          error   = oor_q || (bus.rx_byte != chk_q);
          commit  = !error;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      frameErr_q <= 1'b0;
      errCount_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      data_q     <= '0;
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      wrEn_q     <= commit;
      frameErr_q <= error;
      busy_q     <= (state_d != IDLE);
      if (commit) begin
        wrAddr_q       <= addr_q;
        wrData_q       <= commitData;
        regs_q[addr_q] <= commitData;
      end
      if (error && errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
`ifdef SPI_CMD_CHECKSUM_EN
      data_q     <= data_d;
      chk_q      <= chk_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign bus.wr_en   = wrEn_q;
  assign bus.wr_addr = wrAddr_q;
  assign bus.wr_data = wrData_q;
  assign frame_err   = frameErr_q;
  assign err_count   = errCount_q;
  assign busy        = busy_q;

endmodule
